// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: sizes, state encoding
// and index/one-hot conversion helpers.
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = {SEL_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | SEL_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = {N_REQ{1'b0}};
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin pick: search starts just after 'last' and can
// optionally skip one index (the current owner on a forced switch).
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   input  logic             excl_en,
   input  logic [SEL_W-1:0] excl_idx,
   output logic             pick_vld,
   output logic [SEL_W-1:0] pick_idx
);

   logic [N_REQ-1:0] masked_s;
   logic [N_REQ-1:0] rot_s;
   logic [SEL_W-1:0] base_s;
   logic [SEL_W-1:0] off_s;

   // Mask the excluded requester and rotate so bit 0 is the first candidate.
   always_comb begin
      base_s = last + 2'd1;
      if (excl_en) begin
         masked_s = req & ~idx_to_onehot(excl_idx);
      end else begin
         masked_s = req;
      end
      rot_s = {N_REQ{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         rot_s[k] = masked_s[base_s + SEL_W'(k)];
      end
   end

   // Lowest set rotated bit wins; scan from the top so the last hit is lowest.
   always_comb begin
      pick_vld = 1'b0;
      off_s    = {SEL_W{1'b0}};
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            pick_vld = 1'b1;
            off_s    = SEL_W'(k);
         end else begin
            pick_vld = pick_vld;
         end
      end
      pick_idx = base_s + off_s;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters; drives a
// registered one-hot grant plus the mux select {S1,S0}.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             S0,
   output logic             S1,
   output logic             busy
);

   localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_e       state_r;
   arb_state_e       state_nxt_s;
   logic [SEL_W-1:0] last_r;
   logic [SEL_W-1:0] last_nxt_s;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_nxt_s;
   logic [N_REQ-1:0] gnt_r;
   logic [N_REQ-1:0] gnt_nxt_s;
   logic [SEL_W-1:0] sel_r;
   logic [SEL_W-1:0] sel_nxt_s;
   logic             busy_r;
   logic             busy_nxt_s;
   logic             take_s;
   logic             excl_en_s;
   logic             pick_vld_s;
   logic [SEL_W-1:0] pick_idx_s;

   // While owned, 'last' is the owner; excluding it only matters on a forced switch.
   assign excl_en_s = (state_r == ST_OWN);

   rr_pick u_pick (
      .req      (req),
      .last     (last_r),
      .excl_en  (excl_en_s),
      .excl_idx (last_r),
      .pick_vld (pick_vld_s),
      .pick_idx (pick_idx_s)
   );

   // Next-state, owner pointer and hold counter decisions.
   always_comb begin
      state_nxt_s = state_r;
      last_nxt_s  = last_r;
      hold_nxt_s  = hold_cnt_r;
      take_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_vld_s) begin
               take_s = 1'b1;
            end else begin
               take_s = 1'b0;
            end
         end
         ST_OWN: begin
            if (!req[last_r]) begin
               if (pick_vld_s) begin
                  take_s = 1'b1;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else if (hold_cnt_r == HOLD_LAST) begin
               if (pick_vld_s) begin
                  take_s = 1'b1;
               end else begin
                  hold_nxt_s = {HOLD_W{1'b0}};
               end
            end else begin
               hold_nxt_s = hold_cnt_r + HOLD_W'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      if (take_s) begin
         state_nxt_s = ST_OWN;
         last_nxt_s  = pick_idx_s;
         hold_nxt_s  = {HOLD_W{1'b0}};
      end else begin
         last_nxt_s  = last_nxt_s;
      end
   end

   // Output values for the next edge; select holds its value while idle.
   always_comb begin
      busy_nxt_s = (state_nxt_s == ST_OWN);
      if (busy_nxt_s) begin
         gnt_nxt_s = idx_to_onehot(last_nxt_s);
         sel_nxt_s = onehot_to_idx(gnt_nxt_s);
      end else begin
         gnt_nxt_s = {N_REQ{1'b0}};
         sel_nxt_s = sel_r;
      end
   end

   // State and output registers; reset restarts the search at index 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         last_r     <= 2'd3;
         hold_cnt_r <= {HOLD_W{1'b0}};
         gnt_r      <= 4'b0000;
         sel_r      <= 2'b00;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         last_r     <= last_nxt_s;
         hold_cnt_r <= hold_nxt_s;
         gnt_r      <= gnt_nxt_s;
         sel_r      <= sel_nxt_s;
         busy_r     <= busy_nxt_s;
      end
   end

   assign gnt  = gnt_r;
   assign S0   = sel_r[0];
   assign S1   = sel_r[1];
   assign busy = busy_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a behavioural owner/last/held model
// queues expected outputs per edge; a monitor pops and compares them.
module tb_mux_rr_arbiter;

   localparam int MAXH = 8;

   typedef struct {
      logic [3:0] g;
      logic [1:0] s;
      logic       b;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic       S0, S1, busy;

   int total = 0;
   int bad   = 0;
   exp_t q[$];

   int         m_own  = -1;
   int         m_last = 3;
   int         m_held = 0;
   logic [1:0] m_sel  = 2'b00;

   mux_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .gnt  (gnt),
      .S0   (S0),
      .S1   (S1),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", name, act, want, $time);
      end
   endtask

   function automatic int find(input logic [3:0] r, input int from, input int skip);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (from + k) % 4;
         if (i != skip && r[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_take(input int p);
      m_own  = p;
      m_last = p;
      m_held = 0;
      m_sel  = 2'(p);
   endtask

   task automatic model_step(input logic [3:0] r);
      int p;
      if (m_own < 0) begin
         p = find(r, m_last, -1);
         if (p >= 0) model_take(p);
      end else begin
         p = find(r, m_own, m_own);
         if (!r[m_own]) begin
            if (p >= 0) model_take(p);
            else m_own = -1;
         end else if (m_held == MAXH - 1) begin
            if (p >= 0) model_take(p);
            else m_held = 0;
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.g = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
      e.s = m_sel;
      e.b = (m_own >= 0);
      q.push_back(e);
   endtask

   task automatic step(input logic [3:0] r);
      @(negedge clk);
      req = r;
      model_step(r);
      push_exp();
   endtask

   task automatic hold(input logic [3:0] r, input int n);
      for (int i = 0; i < n; i++) step(r);
   endtask

   // Assert reset between edges and confirm the outputs clear without a clock.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0000;
      #1;
      check("rst_async_gnt", gnt, 4'b0000);
      check("rst_async_busy", {3'b000, busy}, 4'b0000);
      check("rst_async_sel", {2'b00, S1, S0}, 4'b0000);
      m_own  = -1;
      m_last = 3;
      m_held = 0;
      m_sel  = 2'b00;
      push_exp();
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Monitor: pop one expectation per edge and check invariants every cycle.
   always @(posedge clk) begin
      exp_t e;
      logic [1:0] idx;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("gnt", gnt, e.g);
         check("sel", {2'b00, S1, S0}, {2'b00, e.s});
         check("busy", {3'b000, busy}, {3'b000, e.b});
      end
      check("onehot0", {3'b000, $onehot0(gnt)}, 4'b0001);
      check("busy_vs_gnt", {3'b000, busy}, {3'b000, (gnt != 4'b0000)});
      if (busy) begin
         idx = 2'b00;
         for (int i = 0; i < 4; i++) if (gnt[i]) idx = 2'(i);
         check("sel_match", {2'b00, S1, S0}, {2'b00, idx});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #2;
      check("reset_gnt", gnt, 4'b0000);
      check("reset_busy", {3'b000, busy}, 4'b0000);
      check("reset_sel", {2'b00, S1, S0}, 4'b0000);
      rst = 1'b0;

      // single requester, then release to idle with select held
      step(4'b0001);
      hold(4'b0001, 3);
      step(4'b0000);
      hold(4'b0000, 2);

      // full contention: 8-cycle slots rotating 0,1,2,3,0
      do_reset();
      hold(4'b1111, 40);

      // owner 0 drops while 2 waits, then 2 alone across hold wraps, then idle
      do_reset();
      step(4'b0001);
      hold(4'b0101, 3);
      step(4'b0100);
      hold(4'b0100, 20);
      step(4'b0000);
      hold(4'b0000, 2);

      // reset mid-grant of requester 3; search restarts at 0
      do_reset();
      step(4'b1000);
      hold(4'b1000, 3);
      do_reset();
      step(4'b1001);
      hold(4'b1001, 12);

      // random traffic with sticky request patterns so timeouts occur
      begin
         logic [3:0] r;
         r = 4'b0000;
         for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 149) == 0) begin
               do_reset();
            end
            if ($urandom_range(0, 4) == 0) r = 4'($urandom_range(0, 15));
            step(r);
         end
      end

      repeat (2) @(posedge clk);
      #3;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain: got %0d left want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
